// File: rtl/modport_slave.sv
// -----------------------------------------------------------------------------
// modport_slave
//   AXI4-Lite slave exposing a bank of NUM_REGS read/write registers of
//   DATA_WIDTH bits each. Registers are word addressed: the byte offset bits
//   below the word size are ignored. Addresses beyond the bank answer SLVERR;
//   a write there changes nothing and a read there returns zero.
//
// Ports
//   aclk, aresetn             clock (rising edge) / synchronous active-low reset
//   awaddr/awvalid/awready    write address channel (awprot ignored)
//   wdata/wstrb/wvalid/wready write data channel, byte enables in wstrb
//   bresp/bvalid/bready       write response channel
//   araddr/arvalid/arready    read address channel (arprot ignored)
//   rdata/rresp/rvalid/rready read data channel
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module modport_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [2:0]              awprot,

    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,

    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,

    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [2:0]              arprot,

    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int IDX_MSB  = ADDR_LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  r_awready;
    logic                  r_wready;
    logic                  r_arready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  r_aw_latched;
    logic [IDX_W-1:0]      r_aw_idx;
    logic                  r_aw_oor;
    logic                  r_w_latched;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_aw_idx;
    logic                  w_aw_oor;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_oor;
    logic                  w_unused;

    assign w_aw_hs  = r_awready & awvalid;
    assign w_w_hs   = r_wready & wvalid;
    assign w_ar_hs  = r_arready & arvalid;
    assign w_commit = r_aw_latched & r_w_latched & ~r_bvalid;

    // Any set bit above the register index field puts the address past the bank.
    assign w_aw_idx = awaddr[IDX_MSB-1:ADDR_LSB];
    assign w_aw_oor = |awaddr[ADDR_WIDTH-1:IDX_MSB];
    assign w_ar_idx = araddr[IDX_MSB-1:ADDR_LSB];
    assign w_ar_oor = |araddr[ADDR_WIDTH-1:IDX_MSB];

    assign w_unused = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    // Write address / data acceptance and response.
    // Ready is raised for one cycle only; the "~r_*ready" term drops it right
    // after the handshake edge. Latches clear as soon as the write commits, and
    // bvalid then blocks new acceptance until the response is taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_aw_latched <= 1'b0;
            r_aw_idx     <= '0;
            r_aw_oor     <= 1'b0;
            r_w_latched  <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            r_awready <= awvalid & ~r_awready & ~r_aw_latched & ~r_bvalid & ~w_commit;
            r_wready  <= wvalid  & ~r_wready  & ~r_w_latched  & ~r_bvalid & ~w_commit;

            if (w_aw_hs) begin
                r_aw_latched <= 1'b1;
                r_aw_idx     <= w_aw_idx;
                r_aw_oor     <= w_aw_oor;
            end
            if (w_w_hs) begin
                r_w_latched <= 1'b1;
                r_wdata     <= wdata;
                r_wstrb     <= wstrb;
            end

            if (w_commit) begin
                r_aw_latched <= 1'b0;
                r_w_latched  <= 1'b0;
                r_bvalid     <= 1'b1;
                r_bresp      <= r_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register bank: byte-lane update on commit, nothing for out-of-range.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !r_aw_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_wstrb[b]) begin
                    r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel. Data is captured on the address handshake edge from the
    // current bank contents, so a same-edge write is not yet visible.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_arready <= arvalid & ~r_arready & ~r_rvalid;

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_oor ? '0 : r_regs[w_ar_idx];
                r_rresp  <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_modport_slave.sv
module tb_modport_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [2:0]  awprot = 3'b000;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [2:0]  arprot = 3'b000;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [16];
    int          checks = 0;
    int          errors = 0;

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endfunction

    function automatic exp_t model_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
        exp_t e;
        e.data = 32'h0;
        if (addr < 32'd64) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr / 4][8*b +: 8] = data[8*b +: 8];
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b10;
        end
        return e;
    endfunction

    function automatic exp_t model_read(input logic [31:0] addr);
        exp_t e;
        if (addr < 32'd64) begin
            e.resp = 2'b00;
            e.data = model[addr / 4];
        end else begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end
        return e;
    endfunction

    // ---------------- bus drivers (timeouts counted as failed checks) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
        int cnt = 0;
        bit aw_hs = 1'b0;
        bit w_hs = 1'b0;
        @(negedge aclk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while ((awvalid || wvalid || (!aw_hs && cnt < w_lead)) && cnt < 60) begin
            if (awvalid && awready) aw_hs = 1'b1;
            if (wvalid && wready)   w_hs  = 1'b1;
            @(negedge aclk);
            cnt++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            if (!aw_hs && cnt == w_lead) awvalid = 1'b1;
        end
        checks++;
        if (!(aw_hs && w_hs)) begin
            errors++;
            $display("FAIL write_handshake addr=%h: aw_hs=%0b w_hs=%0b, required both 1", addr, aw_hs, w_hs);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            resp    = 2'bxx;
            return;
        end
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            @(negedge aclk);
            cnt++;
        end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL bvalid_timeout addr=%h: bvalid=%b, required 1", addr, bvalid);
        end
        resp = bresp;
    endtask

    task automatic b_accept();
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cnt = 0;
        bit hs = 1'b0;
        @(negedge aclk);
        araddr  = addr;
        arvalid = 1'b1;
        while (arvalid && cnt < 60) begin
            if (arready) hs = 1'b1;
            @(negedge aclk);
            cnt++;
            if (hs) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin
            @(negedge aclk);
            cnt++;
        end
        checks++;
        if (!(hs && rvalid)) begin
            errors++;
            $display("FAIL read_handshake addr=%h: ar_hs=%0b rvalid=%b, required both 1", addr, hs, rvalid);
        end
        data = rdata;
        resp = rresp;
    endtask

    task automatic r_accept();
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        aresetn = 1'b0;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
            errors++;
            $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b b/rvalid=%b%b bresp=%b rresp=%b rdata=%h, required all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        aresetn = 1'b1;
        model_clear();
        exp_q.push_back(model_read(32'h0));
        axi_read(32'h0, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL reset_read0: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_full_write();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_write(32'h4, 32'hDEADBEEF, 4'hF));
        axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, r);
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL full_write_bresp: bresp=%b, required %b", r, e.resp);
        end
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_clear: bvalid=%b after bready, required 0", bvalid);
        end
        exp_q.push_back(model_read(32'h4));
        axi_read(32'h4, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL full_write_read: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_clear: rvalid=%b after rready, required 0", rvalid);
        end
    endtask

    task automatic test_strobe();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_write(32'h4, 32'h12345678, 4'b0101));
        axi_write(32'h4, 32'h12345678, 4'b0101, 0, r);
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL strobe_bresp: bresp=%b, required %b", r, e.resp);
        end
        exp_q.push_back(model_read(32'h4));
        axi_read(32'h4, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || d !== 32'hDE34BE78 || r !== e.resp) begin
            errors++;
            $display("FAIL strobe_read: rdata=%h rresp=%b, required %h (DE34BE78) %b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_w_before_aw();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_write(32'h8, 32'hA5A5A5A5, 4'hF));
        axi_write(32'h8, 32'hA5A5A5A5, 4'hF, 3, r);
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL w_first_bresp: bresp=%b, required %b", r, e.resp);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_first_single_b cycle %0d: bvalid=%b, required 0", i, bvalid);
            end
        end
        exp_q.push_back(model_read(32'h8));
        axi_read(32'h8, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL w_first_read: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_out_of_range();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_write(32'h40, 32'hFFFFFFFF, 4'hF));
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, r);
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_bresp: bresp=%b, required %b", r, e.resp);
        end
        exp_q.push_back(model_read(32'h40));
        axi_read(32'h40, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp || r !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(model_read(32'(i * 4)));
            axi_read(32'(i * 4), d, r);
            r_accept();
            e = exp_q.pop_front();
            checks++;
            if (d !== e.data || r !== e.resp) begin
                errors++;
                $display("FAIL oor_sweep reg %0d: rdata=%h rresp=%b, required %h %b", i, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_write(32'hC, 32'hCAFEF00D, 4'hF));
        axi_write(32'hC, 32'hCAFEF00D, 4'hF, 0, r);
        awaddr  = 32'h10;
        wdata   = 32'h55555555;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b1 || bresp !== r || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cycle %0d: bvalid=%b bresp=%b awready=%b wready=%b, required 1 %b 0 0",
                         i, bvalid, bresp, awready, wready, r);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL b_hold_bresp: bresp=%b, required %b", r, e.resp);
        end
        exp_q.push_back(model_read(32'hC));
        axi_read(32'hC, d, r);
        araddr  = 32'h0;
        arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== d || rresp !== r || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold cycle %0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
                         i, rvalid, rdata, rresp, arready, d, r);
            end
        end
        arvalid = 1'b0;
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL r_hold_read: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] a;
        logic [31:0] v;
        logic [3:0]  s;
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom_range(0, 17)) * 4;
            v = $urandom;
            s = 4'($urandom_range(1, 15));
            exp_q.push_back(model_write(a, v, s));
            axi_write(a, v, s, $urandom_range(0, 2), r);
            b_accept();
            e = exp_q.pop_front();
            checks++;
            if (r !== e.resp) begin
                errors++;
                $display("FAIL b2b_bresp %0d addr=%h: bresp=%b, required %b", i, a, r, e.resp);
            end
            exp_q.push_back(model_read(a));
            axi_read(a, d, r);
            r_accept();
            e = exp_q.pop_front();
            checks++;
            if (d !== e.data || r !== e.resp) begin
                errors++;
                $display("FAIL b2b_read %0d addr=%h: rdata=%h rresp=%b, required %h %b", i, a, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        int          cnt = 0;
        @(negedge aclk);
        awaddr  = 32'h18;
        awvalid = 1'b1;
        while (!awready && cnt < 10) begin
            @(negedge aclk);
            cnt++;
        end
        @(negedge aclk);
        awvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
            errors++;
            $display("FAIL abort_reset_outputs: aw/w/ar_ready=%b%b%b b/rvalid=%b%b rdata=%h, required all 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
        end
        aresetn = 1'b1;
        model_clear();
        exp_q.push_back(model_read(32'h4));
        axi_read(32'h4, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL abort_regs_cleared: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
        exp_q.push_back(model_write(32'h18, 32'h33334444, 4'hF));
        axi_write(32'h18, 32'h33334444, 4'hF, 0, r);
        b_accept();
        e = exp_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL abort_resume_bresp: bresp=%b, required %b", r, e.resp);
        end
        exp_q.push_back(model_read(32'h18));
        axi_read(32'h18, d, r);
        r_accept();
        e = exp_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL abort_resume_read: rdata=%h rresp=%b, required %h %b", d, r, e.data, e.resp);
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_strobe();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
